pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 86 ++++++++
 tb/tb_pipe_stage_reg.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline register chain of DEPTH stages (valid + ctrl + data) with stall, flush and bubble.
// Define PIPE_PERF_CNT_EN to add the bubble_cnt / flush_cnt saturating performance counters.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 160,
  parameter int unsigned CTRL_W = 9,
  parameter int unsigned DEPTH  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              bubble,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam int unsigned LAST = DEPTH - 1;

  logic              valid_q [DEPTH] = '{default: 1'b0};
  logic [CTRL_W-1:0] ctrl_q  [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] data_q  [DEPTH] = '{default: '0};

  // Stage chain: reset/flush clear everything, stall freezes everything and drops the input.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        ctrl_q[k]  <= '0;
        data_q[k]  <= '0;
      end
    end else if (!stall) begin
      if (bubble) begin
        valid_q[0] <= 1'b0;
        ctrl_q[0]  <= '0;
        data_q[0]  <= '0;
      end else begin
        // Invalid slots never carry control bits so no write enable can leak downstream.
        valid_q[0] <= in_valid;
        ctrl_q[0]  <= in_valid ? in_ctrl : '0;
        data_q[0]  <= in_data;
      end
      for (int unsigned k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        ctrl_q[k]  <= ctrl_q[k-1];
        data_q[k]  <= data_q[k-1];
      end
    end
  end

  assign out_valid = valid_q[LAST];
  assign out_ctrl  = ctrl_q[LAST];
  assign out_data  = data_q[LAST];

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] bubble_cnt_q = '0;
  logic [31:0] flush_cnt_q  = '0;

  // Saturating counters of empty output cycles and flush events.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (!valid_q[LAST] && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
      if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: DEPTH=1,2,3 instances share inputs and are checked
// against a queue-based slot model, a directed vector table and hand-written corner sequences.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 160;
  localparam int unsigned CW = 9;
  localparam int unsigned NI = 3;

  typedef struct packed {
    logic          v;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } slot_t;

  typedef struct packed {
    logic          st;
    logic          fl;
    logic          bu;
    logic          v;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic          ev;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          bubble = 1'b0;
  logic          in_valid = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;

  logic          ov [NI];
  logic [CW-1:0] oc [NI];
  logic [DW-1:0] od [NI];
  logic [31:0]   bc [NI];
  logic [31:0]   fc [NI];

  int checks = 0;
  int errors = 0;

  slot_t       mq [NI][$];
  logic [31:0] m_bc [NI];
  logic [31:0] m_fc [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(g + 1)) dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .flush     (flush),
      .bubble    (bubble),
      .in_valid  (in_valid),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .out_valid (ov[g]),
      .out_ctrl  (oc[g]),
      .out_data  (od[g])
`ifdef PIPE_PERF_CNT_EN
      ,
      .bubble_cnt(bc[g]),
      .flush_cnt (fc[g])
`endif
    );
`ifndef PIPE_PERF_CNT_EN
    assign bc[g] = '0;
    assign fc[g] = '0;
`endif
  end

  task automatic chk(input string nm, input int idx, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[depth %0d] got %h want %h", nm, idx + 1, act, exp);
    end
  endtask

  // Pipeline as a queue of slots: newest at the front, the output slot at the back.
  task automatic model_clear(input int i);
    mq[i] = {};
    for (int j = 0; j <= i; j++) mq[i].push_back('0);
  endtask

  task automatic model_step();
    slot_t nw;
    for (int i = 0; i < int'(NI); i++) begin
      if (reset) begin
        m_bc[i] = '0;
        m_fc[i] = '0;
      end else begin
        if (!mq[i][i].v && m_bc[i] != 32'hFFFF_FFFF) m_bc[i] = m_bc[i] + 32'd1;
        if (flush && m_fc[i] != 32'hFFFF_FFFF) m_fc[i] = m_fc[i] + 32'd1;
      end
      if (reset || flush) begin
        model_clear(i);
      end else if (!stall) begin
        if (bubble) nw = '0;
        else nw = '{v: in_valid, c: (in_valid ? in_ctrl : '0), d: in_data};
        mq[i].push_front(nw);
        void'(mq[i].pop_back());
      end
    end
  endtask

  task automatic compare_model();
    for (int i = 0; i < int'(NI); i++) begin
      chk("mdl_valid", i, DW'(ov[i]), DW'(mq[i][i].v));
      chk("mdl_ctrl", i, DW'(oc[i]), DW'(mq[i][i].c));
      chk("mdl_data", i, od[i], mq[i][i].d);
`ifdef PIPE_PERF_CNT_EN
      chk("mdl_bubble_cnt", i, DW'(bc[i]), DW'(m_bc[i]));
      chk("mdl_flush_cnt", i, DW'(fc[i]), DW'(m_fc[i]));
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    reset = 1'b0; stall = 1'b0; flush = 1'b0; bubble = 1'b0;
    in_valid = 1'b0; in_ctrl = '0; in_data = '0;
  endtask

  task automatic do_reset(input int n);
    idle_inputs();
    reset = 1'b1;
    for (int k = 0; k < n; k++) step();
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input logic st, input logic fl, input logic bu, input logic v,
                              input logic [CW-1:0] c, input logic [DW-1:0] d,
                              input logic ev, input logic [CW-1:0] ec, input logic [DW-1:0] ed);
    return '{st: st, fl: fl, bu: bu, v: v, c: c, d: d, ev: ev, ec: ec, ed: ed};
  endfunction

  vec_t tbl [11];

  initial begin
    // DEPTH=3 stream 1..4 with a stall (input 3 dropped), then a bubble and an invalid slot with ctrl set.
    tbl[0]  = mk(0, 0, 0, 1, 9'd1,   DW'(1), 0, 9'd0, DW'(0));
    tbl[1]  = mk(0, 0, 0, 1, 9'd2,   DW'(2), 0, 9'd0, DW'(0));
    tbl[2]  = mk(1, 0, 0, 1, 9'd3,   DW'(3), 0, 9'd0, DW'(0));
    tbl[3]  = mk(0, 0, 0, 1, 9'd4,   DW'(4), 1, 9'd1, DW'(1));
    tbl[4]  = mk(0, 0, 0, 0, 9'd0,   DW'(0), 1, 9'd2, DW'(2));
    tbl[5]  = mk(0, 0, 0, 0, 9'd0,   DW'(0), 1, 9'd4, DW'(4));
    tbl[6]  = mk(0, 0, 0, 0, 9'd0,   DW'(0), 0, 9'd0, DW'(0));
    tbl[7]  = mk(0, 0, 1, 1, 9'h1FF, DW'(7), 0, 9'd0, DW'(0));
    tbl[8]  = mk(0, 0, 0, 0, 9'h1FF, DW'(8), 0, 9'd0, DW'(0));
    tbl[9]  = mk(0, 0, 0, 0, 9'd0,   DW'(0), 0, 9'd0, DW'(0));
    tbl[10] = mk(0, 0, 0, 0, 9'd0,   DW'(0), 0, 9'd0, DW'(8));

    for (int i = 0; i < int'(NI); i++) begin
      model_clear(i);
      m_bc[i] = '0;
      m_fc[i] = '0;
    end

    // Time-zero state before any reset edge.
    #1;
    for (int i = 0; i < int'(NI); i++) begin
      chk("t0_valid", i, DW'(ov[i]), '0);
      chk("t0_ctrl", i, DW'(oc[i]), '0);
      chk("t0_data", i, od[i], '0);
    end

    // DEPTH=1 single transfer after a two-cycle reset.
    do_reset(2);
    chk("rst_valid", 0, DW'(ov[0]), '0);
    chk("rst_valid", 2, DW'(ov[2]), '0);
    in_valid = 1'b1; in_ctrl = 9'h1A5; in_data = DW'(16'hABCD);
    step();
    chk("d1_valid", 0, DW'(ov[0]), DW'(1'b1));
    chk("d1_ctrl", 0, DW'(oc[0]), DW'(9'h1A5));
    chk("d1_data", 0, od[0], DW'(16'hABCD));

    // DEPTH=2 both stages valid, then flush together with stall.
    in_ctrl = 9'h0B2; in_data = DW'(16'h1234);
    step();
    chk("d2_full_valid", 1, DW'(ov[1]), DW'(1'b1));
    chk("d2_full_ctrl", 1, DW'(oc[1]), DW'(9'h1A5));
    flush = 1'b1; stall = 1'b1; in_ctrl = 9'h0C3; in_data = DW'(16'h5678);
    step();
    chk("flush_valid", 1, DW'(ov[1]), '0);
    chk("flush_ctrl", 1, DW'(oc[1]), '0);
    idle_inputs();
    step();
    step();
    chk("post_flush_valid", 1, DW'(ov[1]), '0);

    // Table-driven sequence on the DEPTH=3 instance.
    do_reset(2);
    for (int t = 0; t < 11; t++) begin
      stall = tbl[t].st; flush = tbl[t].fl; bubble = tbl[t].bu;
      in_valid = tbl[t].v; in_ctrl = tbl[t].c; in_data = tbl[t].d;
      step();
      chk($sformatf("tbl%0d_valid", t), 2, DW'(ov[2]), DW'(tbl[t].ev));
      chk($sformatf("tbl%0d_ctrl", t), 2, DW'(oc[2]), DW'(tbl[t].ec));
      chk($sformatf("tbl%0d_data", t), 2, od[2], tbl[t].ed);
    end

    // Randomized traffic against the slot model.
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 99) < 2);
      flush    = ($urandom_range(0, 99) < 5);
      stall    = ($urandom_range(0, 99) < 12);
      bubble   = ($urandom_range(0, 99) < 12);
      in_valid = ($urandom_range(0, 99) < 70);
      in_ctrl  = CW'($urandom);
      in_data  = {$urandom, $urandom, $urandom, $urandom, $urandom};
      step();
    end

`ifdef PIPE_PERF_CNT_EN
    // DEPTH=1 counters: 5 idle cycles plus 2 flushes, then reset clears both.
    do_reset(1);
    for (int k = 0; k < 5; k++) step();
    flush = 1'b1;
    step();
    step();
    flush = 1'b0;
    chk("perf_bubble_cnt", 0, DW'(bc[0]), DW'(32'd7));
    chk("perf_flush_cnt", 0, DW'(fc[0]), DW'(32'd2));
    do_reset(1);
    chk("perf_bubble_rst", 0, DW'(bc[0]), '0);
    chk("perf_flush_rst", 0, DW'(fc[0]), '0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
